// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter side signals of the UART transmit arbiter.
// Handshake: a requester holds req[i] with req_data word i stable until it sees a one-cycle ack[i]; the transmitter gets a one-cycle tx_ena with tx_data and reports tx_busy for the frame.
interface uart_tx_arbiter_if #(
    parameter int D_WIDTH = 13,
    parameter int N_REQ   = 4
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ*D_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]         ack;
    logic                     tx_ena;
    logic [D_WIDTH-1:0]       tx_data;
    logic                     tx_busy;

    modport master (output req, req_data, tx_busy, input ack, tx_ena, tx_data);
    modport slave  (input req, req_data, tx_busy, output ack, tx_ena, tx_data);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ requesters;
// grants only while the transmitter is idle and follows tx_busy through each frame.
module uart_tx_arbiter #(
    parameter int D_WIDTH = 13,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   bus,
    output logic [2:0]         gnt_id,
    output logic               active,
    output logic               err_timeout,
    output logic [1:0]         state_dbg
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [N_REQ-1:0]   ack_q;
    logic               tx_ena_q;
    logic [D_WIDTH-1:0] tx_data_q;
    logic [2:0]         win;
    logic [N_REQ-1:0]   win_oh;

    // gnt_id doubles as the round-robin pointer: it always holds the last winner.
    // Searching offsets from far to near lets the nearest requester win.
    always_comb begin
        win    = gnt_id;
        win_oh = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (bus.req[j] && (j == (int'(gnt_id) + i) % N_REQ)) win = 3'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (3'(j) == win) win_oh[j] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ack_q       <= '0;
            tx_ena_q    <= 1'b0;
            tx_data_q   <= '0;
            gnt_id      <= 3'(N_REQ - 1);
            active      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            ack_q    <= '0;
            tx_ena_q <= 1'b0;
            case (state)
                IDLE: begin
                    if ((|bus.req) && !bus.tx_busy) begin
                        tx_data_q <= bus.req_data[int'(win)*D_WIDTH +: D_WIDTH];
                        ack_q     <= win_oh;
                        gnt_id    <= win;
                        active    <= 1'b1;
                        tx_ena_q  <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // Transmitter never acknowledged the issue; give up on this frame.
                        err_timeout <= 1'b1;
                        active      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack     = ack_q;
    assign bus.tx_ena  = tx_ena_q;
    assign bus.tx_data = tx_data_q;
    assign state_dbg   = state;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model that
// answers each tx_ena with a fixed-length busy frame.
module tb_uart_tx_arbiter;
    localparam int DW    = 13;
    localparam int NR    = 4;
    localparam int TO    = 8;
    localparam int FRAME = 6;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.D_WIDTH(DW), .N_REQ(NR)) bus ();
    logic [2:0] gnt_id;
    logic       active;
    logic       err_timeout;
    logic [1:0] state_dbg;

    uart_tx_arbiter #(.D_WIDTH(DW), .N_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .gnt_id(gnt_id), .active(active), .err_timeout(err_timeout), .state_dbg(state_dbg)
    );

    int checks   = 0;
    int failures = 0;

    // transmitter model; not reset by rst_n, like the real transmitter
    logic xmit_en    = 1'b1;
    logic busy_force = 1'b0;
    logic model_busy = 1'b0;
    int   frame_cnt  = 0;
    assign bus.tx_busy = model_busy | busy_force;

    always @(posedge clk) begin
        if (model_busy) begin
            if (frame_cnt == 1) model_busy <= 1'b0;
            frame_cnt <= frame_cnt - 1;
        end else if (bus.tx_ena && xmit_en) begin
            model_busy <= 1'b1;
            frame_cnt  <= FRAME;
        end
    end

    int ena_cnt      = 0;
    int ena_busy_cnt = 0;
    always @(posedge clk) begin
        if (bus.tx_ena) ena_cnt <= ena_cnt + 1;
        if (bus.tx_ena && bus.tx_busy) ena_busy_cnt <= ena_busy_cnt + 1;
    end

    logic [2:0] exp_q[$];

    // driver tasks
    task automatic set_word(input int i, input logic [DW-1:0] val);
        bus.req_data[i*DW +: DW] = val;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!active && !bus.tx_busy && state_dbg == 2'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.req = '0;
        bus.req_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", bus.ack); end
        checks++; if (bus.tx_ena !== 1'b0) begin failures++; $display("FAIL reset_tx_ena got=%b exp=0", bus.tx_ena); end
        checks++; if (bus.tx_data !== 13'h0) begin failures++; $display("FAIL reset_tx_data got=%h exp=0", bus.tx_data); end
        checks++; if (gnt_id !== 3'd3) begin failures++; $display("FAIL reset_gnt_id got=%0d exp=3", gnt_id); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    endtask

    task automatic test_single();
        int e0;
        bit hold;
        e0 = ena_cnt;
        @(negedge clk);
        set_word(0, 13'h1A5);
        bus.req = 4'b0001;
        @(negedge clk);
        checks++; if (bus.ack !== 4'b0001) begin failures++; $display("FAIL single_ack got=%b exp=0001", bus.ack); end
        checks++; if (bus.tx_ena !== 1'b1) begin failures++; $display("FAIL single_tx_ena got=%b exp=1", bus.tx_ena); end
        checks++; if (gnt_id !== 3'd0) begin failures++; $display("FAIL single_gnt got=%0d exp=0", gnt_id); end
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL single_active got=%b exp=1", active); end
        checks++; if (bus.tx_data !== 13'h1A5) begin failures++; $display("FAIL single_data got=%h exp=1a5", bus.tx_data); end
        bus.req = '0;
        set_word(0, 13'h0F0);
        hold = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!active) break;
            if (bus.tx_data !== 13'h1A5 || bus.ack !== 4'b0000 || bus.tx_ena !== 1'b0) hold = 1'b0;
        end
        checks++; if (!hold) begin failures++; $display("FAIL single_hold got=0 exp=1 (data/ack/tx_ena not stable during frame)"); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL single_frame_end got=%b exp=0", active); end
        checks++; if (ena_cnt - e0 !== 1) begin failures++; $display("FAIL single_ena_count got=%0d exp=1", ena_cnt - e0); end
    endtask

    task automatic test_all_req();
        int e0, b0;
        bit ok;
        logic [2:0] id;
        logic [DW-1:0] w;
        apply_reset();
        e0 = ena_cnt;
        b0 = ena_busy_cnt;
        set_word(0, 13'h101); set_word(1, 13'h202); set_word(2, 13'h303); set_word(3, 13'h404);
        bus.req = 4'b1111;
        exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
        exp_q.push_back(3'd3); exp_q.push_back(3'd0);
        while (exp_q.size() > 0) begin
            id = exp_q.pop_front();
            wait_ack(60, ok);
            checks++;
            if (!ok) begin
                failures++; $display("FAIL all_req_timeout got=no_ack exp=ack%0d", id);
            end else if (bus.ack !== (4'b0001 << id)) begin
                failures++; $display("FAIL all_req_order got=%b exp=%b", bus.ack, 4'b0001 << id);
            end
            w = 13'((int'(id) + 1) * 13'h101);
            checks++; if (bus.tx_data !== w) begin failures++; $display("FAIL all_req_data got=%h exp=%h", bus.tx_data, w); end
        end
        bus.req = '0;
        wait_idle(60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL all_req_idle got=busy exp=idle"); end
        checks++; if (ena_cnt - e0 !== 5) begin failures++; $display("FAIL all_req_ena_count got=%0d exp=5", ena_cnt - e0); end
        checks++; if (ena_busy_cnt - b0 !== 0) begin failures++; $display("FAIL all_req_ena_while_busy got=%0d exp=0", ena_busy_cnt - b0); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [2:0] id;
        apply_reset();
        bus.req = 4'b0100;
        wait_ack(20, ok);
        checks++; if (!ok || bus.ack !== 4'b0100) begin failures++; $display("FAIL wrap_setup got=%b exp=0100", bus.ack); end
        bus.req = '0;
        wait_idle(60, ok);
        bus.req = 4'b0011;
        exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd0);
        while (exp_q.size() > 0) begin
            id = exp_q.pop_front();
            wait_ack(60, ok);
            checks++;
            if (!ok || bus.ack !== (4'b0001 << id) || gnt_id !== id) begin
                failures++; $display("FAIL wrap_order got=%b/%0d exp=%b/%0d", bus.ack, gnt_id, 4'b0001 << id, id);
            end
        end
        bus.req = '0;
        wait_idle(60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_idle got=busy exp=idle"); end
    endtask

    task automatic test_timeout();
        bit ok;
        xmit_en = 1'b0;
        bus.req = 4'b0010;
        wait_ack(20, ok);
        checks++; if (!ok || bus.ack !== 4'b0010) begin failures++; $display("FAIL timeout_ack got=%b exp=0010", bus.ack); end
        bus.req = '0;
        repeat (8) @(negedge clk);
        checks++; if (active !== 1'b1 || err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b%b exp=10", active, err_timeout); end
        @(negedge clk);
        checks++; if (active !== 1'b0 || err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_abort got=%b%b exp=01", active, err_timeout); end
        checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL timeout_state got=%0d exp=0", state_dbg); end
        xmit_en = 1'b1;
        bus.req = 4'b1000;
        wait_ack(20, ok);
        checks++; if (!ok || bus.ack !== 4'b1000 || gnt_id !== 3'd3) begin failures++; $display("FAIL timeout_regrant got=%b/%0d exp=1000/3", bus.ack, gnt_id); end
        bus.req = '0;
        wait_idle(60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL timeout_frame got=busy exp=idle"); end
        checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b exp=1", err_timeout); end
    endtask

    task automatic test_busy_entry();
        bit quiet, ok;
        int b0;
        b0 = ena_busy_cnt;
        @(negedge clk);
        busy_force = 1'b1;
        bus.req = 4'b0100;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.ack !== 4'b0000) quiet = 1'b0;
        end
        checks++; if (!quiet) begin failures++; $display("FAIL busy_entry_quiet got=ack exp=no_ack"); end
        busy_force = 1'b0;
        @(negedge clk);
        checks++; if (bus.ack !== 4'b0100) begin failures++; $display("FAIL busy_entry_ack got=%b exp=0100", bus.ack); end
        bus.req = '0;
        wait_idle(60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL busy_entry_idle got=busy exp=idle"); end
        checks++; if (ena_busy_cnt - b0 !== 0) begin failures++; $display("FAIL busy_entry_ena_while_busy got=%0d exp=0", ena_busy_cnt - b0); end
    endtask

    task automatic test_reset_mid();
        bit ok, early, saw_idle;
        bus.req = 4'b0010;
        wait_ack(20, ok);
        bus.req = '0;
        repeat (3) @(negedge clk);
        checks++; if (state_dbg !== 2'd3 || bus.tx_busy !== 1'b1) begin failures++; $display("FAIL mid_setup got=%0d/%b exp=3/1", state_dbg, bus.tx_busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.ack !== 4'b0000 || bus.tx_ena !== 1'b0 || bus.tx_data !== 13'h0) begin failures++; $display("FAIL mid_reset_bus got=%b/%b/%h exp=0000/0/0", bus.ack, bus.tx_ena, bus.tx_data); end
        checks++; if (gnt_id !== 3'd3 || active !== 1'b0 || err_timeout !== 1'b0) begin failures++; $display("FAIL mid_reset_status got=%0d/%b/%b exp=3/0/0", gnt_id, active, err_timeout); end
        bus.req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        early = 1'b0;
        saw_idle = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ack !== 4'b0000) early = 1'b1;
            if (!bus.tx_busy) begin
                saw_idle = 1'b1;
                break;
            end
        end
        checks++; if (early || !saw_idle) begin failures++; $display("FAIL mid_grant_while_busy got=%b/%b exp=0/1", early, saw_idle); end
        wait_ack(10, ok);
        checks++; if (!ok || bus.ack !== 4'b0001 || gnt_id !== 3'd0) begin failures++; $display("FAIL mid_first_grant got=%b/%0d exp=0001/0", bus.ack, gnt_id); end
        bus.req = '0;
        wait_idle(60, ok);
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_req();
        test_wrap();
        test_timeout();
        test_busy_entry();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among N_REQ requesters. It picks one pending requester, latches that requester's data word, and issues a one-cycle `tx_ena` to the transmitter. It then tracks the transmitter's `tx_busy` through the whole frame before granting again. It sits between the protocol/command blocks and the single UART transmit datapath.

## Interface
- `D_WIDTH`, 13: data word width; matches the transmitter's `tx_data`.
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 8: cycles to wait for `tx_busy` to rise after issue.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  N_REQ: per-requester send request; level, held until acked.
- `req_data`  in  N_REQ*D_WIDTH: flat bus; requester i owns bits [i*D_WIDTH +: D_WIDTH].
- `ack`  out  N_REQ: one-cycle pulse; data of requester i has been latched.
- `tx_ena`  out  1: to transmitter; one-cycle issue pulse.
- `tx_data`  out  D_WIDTH: to transmitter; latched word, stable from issue to frame end.
- `tx_busy`  in  1: from transmitter.
- `gnt_id`  out  3: index of the current or most recent grant.
- `active`  out  1: high from grant until the frame completes or aborts.
- `err_timeout`  out  1: sticky; set when `tx_busy` never rose after an issue.

## Operation
- All outputs are registered. Reset values: `ack`=0, `tx_ena`=0, `tx_data`=0, `gnt_id`=N_REQ-1, `active`=0, `err_timeout`=0. The round-robin pointer `last`=N_REQ-1. The FSM is in IDLE.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: if `req`≠0 and `tx_busy`=0, select the winner w, latch `tx_data`←word w, pulse `ack`[w], set `gnt_id`←w, `last`←w, `active`←1, `tx_ena`←1, and go to ISSUE. Otherwise stay. If `tx_busy`=1 (transmitter held by another master or still draining), no grant.
- Winner selection: the first asserted `req` bit searching upward from (`last`+1) mod N_REQ, with wrap-around. This is a purely combinational search over the registered pointer.
- ISSUE: `tx_ena`←0, clear the timeout counter, go to WAIT_BUSY. The transmitter samples `tx_ena`=1 on this edge.
- WAIT_BUSY: if `tx_busy`=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches TIMEOUT-1 with `tx_busy` still 0, set `err_timeout`←1, `active`←0, and go to IDLE (abort).
- WAIT_DONE: stay while `tx_busy`=1. On `tx_busy`=0, `active`←0 and go to IDLE.
- Requester rules:
  - A requester drops `req` in the cycle after its `ack`.
  - If it holds `req` high, it is served again only after every other pending requester has had one grant.
  - Dropping `req` before `ack` withdraws the request with no side effect.
- `req_data` is sampled only in the IDLE grant cycle. Changes at any other time have no effect.
- Async reset asserted mid-frame returns everything to reset values immediately. The transmitter is not aborted. The next grant waits for `tx_busy`=0.
- Counter width is ceil(log2(TIMEOUT))+1 bits; no wrap occurs within a wait.

## Timing
- `ack` and `tx_ena` rise on the same edge: one cycle after the edge where `req` is seen in IDLE with `tx_busy`=0.
- `tx_ena` is high for exactly one cycle.
- `tx_busy` is expected high in the first WAIT_BUSY cycle, i.e. 2 cycles after `ack`.
- Frame end: `active` falls on the edge after `tx_busy` is first sampled low in WAIT_DONE.
- Earliest next grant is the edge after that, so back-to-back frames have at least 2 idle cycles between `tx_busy` fall and the next `tx_ena`.
- With the default transmitter (13-bit data), a frame holds `tx_busy` for about 17 cycles. Grant-to-next-grant is about 21 cycles.

## Test plan
- Single request: `req`=0001, data 0x1A5, `tx_busy` model responds → `ack`=0001 for one cycle; `tx_ena` pulses once; `tx_data`=0x1A5 until `active` falls; `gnt_id`=0.
- All requesting: `req`=1111 held constantly → grant order 0,1,2,3,0,… with exactly one `tx_ena` per frame; no grant while `tx_busy`=1.
- Pointer wrap: `last`=2 and `req`=0011 → grant 0, then 1, then 0.
- Timeout: transmitter model never raises `tx_busy` → after TIMEOUT=8 cycles in WAIT_BUSY, `err_timeout`=1 (sticky) and `active`=0; the next request is granted normally.
- Busy at entry: `tx_busy`=1 externally with `req`=0100 → no `ack`; when `tx_busy` falls, `ack`[2] pulses on the next edge.
- Reset mid-frame: `rst_n` low during WAIT_DONE → all outputs at reset values immediately; after release, the next grant waits for `tx_busy`=0 and goes to requester 0 first.
